sprite_draw_sched: RTL
======================

// Module: sprite_draw_sched
// PURPOSE
//  Round-robin scheduler in front of the single sprite_draw engine. Up to NREQ clients (player, boxes,
//  board redraw) submit 8x8 tile draws (x, y, sprite id) via valid/ready. Grants one draw at a time,
//  pulses the engine's go, holds off for the engine's fixed draw time, then reports completion to the
//  granted client. Sits between game logic and sprite_draw (x_in/y_in/sprite_id_in/begin_draw).
// PARAMETERS
//  NREQ         3    number of requesting clients (2..8)
//  DRAW_CYCLES  66   cycles the engine is busy after go falls (1 load + 64 pixels + 1 margin); >=1
// PORTS
//  clk          in   1          system clock (rising edge)
//  resetn       in   1          asynchronous, active-low reset
//  req_valid    in   NREQ       client i has a draw pending
//  req_x        in   NREQ*8     client i tile anchor x (slice [8i+7:8i])
//  req_y        in   NREQ*7     client i tile anchor y (slice [7i+6:7i])
//  req_id       in   NREQ*3     client i sprite id
//  req_ready    out  NREQ       one-hot; transfer on req_valid[i] & req_ready[i]
//  req_done     out  NREQ       one-hot 1-cycle pulse: client i's draw finished
//  draw_x       out  8          to engine x_in (registered)
//  draw_y       out  7          to engine y_in (registered)
//  draw_id      out  3          to engine sprite_id_in (registered)
//  draw_go      out  1          to engine begin_draw (registered)
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  States IDLE, GO, WAIT. Reset (async): state IDLE, draw_x/y/id=0, draw_go=0, req_done=0, rr pointer=0,
//   cnt=0. req_ready is combinational, so it is 0 while resetn low.
//  IDLE: req_ready = one-hot grant from arbiter over req_valid (0 if none valid); ready never asserted
//   outside IDLE. On transfer: latch x/y/id of winner into draw_*, store grant index, draw_go<=1, ->GO.
//  GO: exactly one cycle, draw_go=1 (engine loads coords while go high). Next edge: draw_go<=0,
//   cnt<=DRAW_CYCLES-1, ->WAIT.
//  WAIT: cnt decrements each cycle; draw_* held stable. When cnt==0: req_done[granted]<=1 for one cycle,
//   advance rr pointer to granted+1 (mod NREQ), ->IDLE.
//  Latency: transfer edge T -> draw_go high T+1 -> done pulse high at T+2+DRAW_CYCLES. Next grant may
//   transfer in the same cycle done is high (IDLE). Per-draw period = DRAW_CYCLES+2 cycles.
//  Arbitration: round-robin starting at rr pointer; pointer moves only on completion, so a client
//   cannot win twice while others wait. Single requester gets back-to-back service.
//  Client rule: req_x/y/id must be stable while req_valid high; dropping valid before ready = withdrawal,
//   no transfer, no done.
//  Widths: cnt is $clog2(DRAW_CYCLES) bits (min 1); no coordinate arithmetic (engine adds offsets;
//   clients keep x<=152, y<=112).
//  Reset mid-GO/WAIT: returns to IDLE immediately, draw_go drops, no req_done for aborted draw.
// CONFIGURATION
//  SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins (client 0 = player), rr pointer
//   removed. Undefined (default): round-robin as above. Ports/timing identical in both builds.
// STRUCTURE
//  Package sprite_pkg: SPR_X_W=8, SPR_Y_W=7, SPR_ID_W=3, SPR_PIXELS=64, SPR_DRAW_CYCLES=66, state enum
//   {S_IDLE,S_GO,S_WAIT}.
//  Sub-module sprite_rr_arb (NREQ): inputs req, ptr; output one-hot grant + index; fixed-priority when
//   SCHED_FIXED_PRIO_EN. Top holds FSM, counter, coord registers.
// TESTING
//  1 single: client1 valid x=16,y=24,id=2 -> ready1 same cycle; draw_go high 1 cycle with draw_x=16,
//    draw_y=24, draw_id=2; req_done[1] exactly 68 cycles after transfer edge; busy low after.
//  2 contention: all 3 valid from reset -> grant order 0,1,2, transfers 68 cycles apart; no ready overlap.
//  3 fairness: client0 re-requests immediately after each done, client2 valid -> order 0,2,0,2.
//  4 reset: assert resetn low 10 cycles into WAIT -> draw_go=0, busy=0, no req_done; after release
//    pending client0 granted normally.
//  5 withdrawal/hold: valid drops while another draw in WAIT -> no transfer; draw_* unchanged
//    throughout WAIT while req_x toggles.
//  6 macro: build with SCHED_FIXED_PRIO_EN, clients 0 and 2 always valid -> client0 wins every grant.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared widths, timing constants and scheduler state encoding for the sprite draw path.
// Build option SCHED_FIXED_PRIO_EN (see sprite_rr_arb) selects fixed-priority arbitration.
package sprite_pkg;

  localparam int SPR_X_W         = 8;
  localparam int SPR_Y_W         = 7;
  localparam int SPR_ID_W        = 3;
  localparam int SPR_PIXELS      = 64;
  localparam int SPR_DRAW_CYCLES = 66;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GO   = 2'd1,
    S_WAIT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sprite_rr_arb.sv
// Request arbiter for the sprite scheduler: round-robin from ptr by default,
// fixed priority (lowest index wins, ptr ignored) when SCHED_FIXED_PRIO_EN is defined.
module sprite_rr_arb
  import sprite_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

`ifdef SCHED_FIXED_PRIO_EN

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

`else

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan ptr, ptr+1, ... wrapping at NREQ; the first valid client wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NREQ)) cand = cand - (IDX_W+1)'(NREQ);
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

`endif

endmodule

// File: rtl/sprite_draw_sched.sv
// Schedules client tile draws onto the single sprite_draw engine, one at a time.
// Build option SCHED_FIXED_PRIO_EN: fixed priority instead of round-robin (no rr pointer).
module sprite_draw_sched
  import sprite_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int DRAW_CYCLES = SPR_DRAW_CYCLES
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*SPR_X_W-1:0]  req_x,
  input  logic [NREQ*SPR_Y_W-1:0]  req_y,
  input  logic [NREQ*SPR_ID_W-1:0] req_id,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          req_done,
  output logic [SPR_X_W-1:0]       draw_x,
  output logic [SPR_Y_W-1:0]       draw_y,
  output logic [SPR_ID_W-1:0]      draw_id,
  output logic                     draw_go,
  output logic                     busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;

  sched_state_e     state, state_nx;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             finish;
  logic [NREQ-1:0]  done_nx;

  sprite_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Handshake: a client holds req_valid with stable x/y/id; ready is offered only
  // in IDLE to the arbiter winner; the draw is accepted on the edge where valid & ready.
  // Dropping valid before that edge withdraws the request.
  assign req_ready = (resetn && state == S_IDLE) ? grant : '0;
  assign xfer      = |req_ready;
  assign finish    = (state == S_WAIT) && (cnt == '0);
  assign busy      = (state != S_IDLE);

  always_comb begin
    done_nx = '0;
    if (finish) done_nx[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (xfer) state_nx = S_GO;
      S_GO:    state_nx = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      draw_x   <= '0;
      draw_y   <= '0;
      draw_id  <= '0;
      draw_go  <= 1'b0;
      owner    <= '0;
      cnt      <= '0;
      req_done <= '0;
    end else begin
      draw_go  <= (state == S_IDLE) && xfer;
      req_done <= done_nx;
      if (state == S_IDLE && xfer) begin
        draw_x  <= req_x[grant_idx*SPR_X_W +: SPR_X_W];
        draw_y  <= req_y[grant_idx*SPR_Y_W +: SPR_Y_W];
        draw_id <= req_id[grant_idx*SPR_ID_W +: SPR_ID_W];
        owner   <= grant_idx;
      end
      // The engine stays busy for DRAW_CYCLES cycles after go falls.
      if (state == S_GO)
        cnt <= CNT_W'(DRAW_CYCLES - 1);
      else if (state == S_WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

`ifdef SCHED_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // Pointer only moves on completion, so a waiting client cannot be skipped twice.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rr_ptr <= '0;
    else if (finish)
      rr_ptr <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
  end
`endif

endmodule
